// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot/fetch/exception FSM that drives the fetch address and PC mux select.
// Optional misaligned-branch trapping is compiled in with `define PC_SEQ_MISALIGN_CHECK_EN.
module pc_sequencer #(
    parameter int                  PC_SIZE    = 32,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = 32'h0000_0000,
    parameter logic [PC_SIZE-1:0]  EXC_VECTOR = 32'h0000_0100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_fetch_ack,
    input  logic               i_branch_taken,
    input  logic [PC_SIZE-1:0] i_branch_target,
    input  logic               i_exception,
    input  logic               i_eret,
    output logic [PC_SIZE-1:0] o_pc,
    output logic               o_fetch_req,
    output logic [1:0]         o_pc_select,
    output logic [PC_SIZE-1:0] o_exc_addr,
    output logic [PC_SIZE-1:0] o_epc,
    output logic               o_in_exception,
    output logic               o_misalign
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXC   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_EXC = 2'b10;

    state_t             state_reg;
    logic [PC_SIZE-1:0] pc_reg;
    logic [PC_SIZE-1:0] epc_reg;
    logic               misalign_reg;

    logic advance;
    logic exc_entry;
    logic eret_accept;
    logic branch_accept;
    logic misalign_trap;

    always_comb begin
        advance       = i_fetch_ack && !i_stall;
        eret_accept   = (state_reg == S_EXC) && i_eret && advance;
        branch_accept = (state_reg != S_BOOT) && i_branch_taken && advance &&
                        !eret_accept && !((state_reg == S_FETCH) && i_exception);
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        misalign_trap = branch_accept && i_branch_target[0];
`else
        misalign_trap = 1'b0;
`endif
        // A misaligned branch in S_FETCH is promoted to a full exception entry.
        exc_entry = (state_reg == S_FETCH) && (i_exception || misalign_trap);
    end

    always_comb begin
        o_pc_select = SEL_SEQ;
        if (state_reg != S_BOOT) begin
            if (exc_entry || eret_accept)
                o_pc_select = SEL_EXC;
            else if (i_branch_taken)
                o_pc_select = SEL_IMM;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_BOOT;
            pc_reg       <= RESET_PC;
            epc_reg      <= '0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_trap;
            case (state_reg)
                S_BOOT: begin
                    state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    if (exc_entry) begin
                        epc_reg   <= pc_reg;
                        pc_reg    <= EXC_VECTOR;
                        state_reg <= S_EXC;
                    end else if (branch_accept) begin
                        pc_reg <= i_branch_target;
                    end else if (advance) begin
                        pc_reg <= pc_reg + PC_SIZE'(4);
                    end
                end
                S_EXC: begin
                    if (eret_accept) begin
                        pc_reg    <= epc_reg;
                        state_reg <= S_FETCH;
                    end else if (branch_accept) begin
                        // Misaligned targets cannot nest a trap here, so the PC simply holds.
                        if (!misalign_trap)
                            pc_reg <= i_branch_target;
                    end else if (advance) begin
                        pc_reg <= pc_reg + PC_SIZE'(4);
                    end
                end
                default: begin
                    state_reg <= S_BOOT;
                end
            endcase
        end
    end

    assign o_pc           = pc_reg;
    assign o_epc          = epc_reg;
    assign o_in_exception = (state_reg == S_EXC);
    assign o_fetch_req    = (state_reg != S_BOOT) && !i_stall;
    assign o_exc_addr     = (state_reg == S_EXC) ? epc_reg : EXC_VECTOR;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    assign o_misalign     = misalign_reg;
`else
    assign o_misalign     = 1'b0;
    logic unused_misalign;
    assign unused_misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: boot sequence, branches, exceptions, wrap, misalign, reset.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetch_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exception;
    logic        eret;
    logic [31:0] pc;
    logic        fetch_req;
    logic [1:0]  pc_select;
    logic [31:0] exc_addr;
    logic [31:0] epc;
    logic        in_exception;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_fetch_ack     (fetch_ack),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_exception     (exception),
        .i_eret          (eret),
        .o_pc            (pc),
        .o_fetch_req     (fetch_req),
        .o_pc_select     (pc_select),
        .o_exc_addr      (exc_addr),
        .o_epc           (epc),
        .o_in_exception  (in_exception),
        .o_misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; fetch_ack = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; exception = 1'b0; eret = 1'b0;
    endtask

    // Take a branch from S_FETCH to reposition the PC.
    task automatic jump(input logic [31:0] target);
        idle_inputs();
        fetch_ack = 1'b1; branch_taken = 1'b1; branch_target = target;
        tick();
        idle_inputs();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        fetch_ack = 1'b1;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_in_exc", {31'h0, in_exception}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_fetch_req", {31'h0, fetch_req}, 32'h0);

        rst = 1'b0;
        #1;
        check("boot_fetch_req", {31'h0, fetch_req}, 32'h0);
        tick();
        check("boot_pc", pc, 32'h0);
        check("fetch_req_after_boot", {31'h0, fetch_req}, 32'h1);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);
        tick(); check("seq_pc12", pc, 32'hC);
        tick(); check("seq_pc16", pc, 32'h10);

        // Branch with ack, then branch without ack
        branch_taken = 1'b1; branch_target = 32'h40; #1;
        check("br_select", {30'h0, pc_select}, 32'h1);
        tick(); check("br_pc", pc, 32'h40);
        jump(32'h10);
        check("rejump_pc", pc, 32'h10);
        fetch_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40; #1;
        check("br_noack_select", {30'h0, pc_select}, 32'h1);
        tick(); check("br_noack_pc", pc, 32'h10);

        // Stall holds PC and drops the fetch request
        idle_inputs(); fetch_ack = 1'b1; stall = 1'b1; #1;
        check("stall_fetch_req", {31'h0, fetch_req}, 32'h0);
        check("stall_select", {30'h0, pc_select}, 32'h0);
        tick(); check("stall_pc", pc, 32'h10);

        // Exception + branch while stalled: exception wins
        jump(32'h20);
        exception = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1; #1;
        check("exc_select", {30'h0, pc_select}, 32'h2);
        check("exc_addr_fetch", exc_addr, 32'h100);
        tick();
        check("exc_pc", pc, 32'h100);
        check("exc_epc", epc, 32'h20);
        check("exc_in_exc", {31'h0, in_exception}, 32'h1);
        check("exc_addr_exc", exc_addr, 32'h20);

        idle_inputs(); fetch_ack = 1'b1;
        tick(); check("handler_seq_pc", pc, 32'h104);
        exception = 1'b1; #1;
        check("nested_exc_select", {30'h0, pc_select}, 32'h0);
        tick();
        check("nested_exc_epc", epc, 32'h20);
        check("nested_exc_pc", pc, 32'h108);

        idle_inputs(); eret = 1'b1; #1;
        check("eret_noack_select", {30'h0, pc_select}, 32'h0);
        tick(); check("eret_noack_pc", pc, 32'h108);
        fetch_ack = 1'b1; #1;
        check("eret_select", {30'h0, pc_select}, 32'h2);
        tick();
        check("eret_pc", pc, 32'h20);
        check("eret_in_exc", {31'h0, in_exception}, 32'h0);
        idle_inputs(); eret = 1'b1; fetch_ack = 1'b1; #1;
        check("eret_in_fetch_select", {30'h0, pc_select}, 32'h0);
        tick(); check("eret_in_fetch_pc", pc, 32'h24);

        // Wrap at the top of the address space
        jump(32'hFFFF_FFFC);
        check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
        fetch_ack = 1'b1;
        tick(); check("wrap_pc", pc, 32'h0);

        // Odd branch target
        jump(32'h30);
        fetch_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h41; #1;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        check("mis_select", {30'h0, pc_select}, 32'h2);
        tick();
        check("mis_pc", pc, 32'h100);
        check("mis_epc", epc, 32'h30);
        check("mis_pulse", {31'h0, misalign}, 32'h1);
        idle_inputs();
        tick();
        check("mis_pulse_end", {31'h0, misalign}, 32'h0);
`else
        check("mis_select", {30'h0, pc_select}, 32'h1);
        tick();
        check("mis_pc", pc, 32'h41);
        check("mis_flag", {31'h0, misalign}, 32'h0);
        idle_inputs(); exception = 1'b1;
        tick();
        check("pre_rst_in_exc", {31'h0, in_exception}, 32'h1);
        check("pre_rst_epc", epc, 32'h41);
`endif

        // Reset for one cycle while in S_EXC with inputs active
        idle_inputs(); stall = 1'b1; exception = 1'b1; eret = 1'b1; fetch_ack = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("exc_rst_pc", pc, 32'h0);
        check("exc_rst_epc", epc, 32'h0);
        check("exc_rst_in_exc", {31'h0, in_exception}, 32'h0);
        check("exc_rst_fetch_req", {31'h0, fetch_req}, 32'h0);
        idle_inputs(); fetch_ack = 1'b1;
        tick(); check("exc_rst_boot_pc", pc, 32'h0);
        tick(); check("exc_rst_seq_pc", pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_SIZE, default 32: width of every PC-valued port and register.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0100: exception handler entry address.
REQ-004 i_clk  input  1  single clock, all state on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_stall  input  1  pipeline stall; hold PC, suppress fetch request.
REQ-007 i_fetch_ack  input  1  instruction memory accepted current o_pc.
REQ-008 i_branch_taken  input  1  branch resolved taken this cycle.
REQ-009 i_branch_target  input  PC_SIZE  precomputed PC + (imm << 1).
REQ-010 i_exception  input  1  exception request.
REQ-011 i_eret  input  1  return from exception handler.
REQ-012 o_pc  output  PC_SIZE  current fetch address (registered).
REQ-013 o_fetch_req  output  1  fetch request for o_pc.
REQ-014 o_pc_select  output  2  select code for the PC select mux: 2'b00 add-4, 2'b01 add-imm, 2'b10 exception; never 2'b11.
REQ-015 o_exc_addr  output  PC_SIZE  value for the mux exception input: EXC_VECTOR in S_FETCH, EPC in S_EXC.
REQ-016 o_epc  output  PC_SIZE  saved exception PC.
REQ-017 o_in_exception  output  1  high while in S_EXC.
REQ-018 o_misalign  output  1  one-cycle pulse, misaligned branch target trapped (see Configuration).

Function
REQ-019 FSM states S_BOOT, S_FETCH, S_EXC; S_BOOT -> S_FETCH unconditionally after one cycle.
REQ-020 S_BOOT: o_fetch_req=0, PC held, all inputs ignored.
REQ-021 S_FETCH/S_EXC: o_fetch_req = !i_stall.
REQ-022 o_pc_select combinational, priority: exception-class event (10) > i_branch_taken (01) > sequential (00).
REQ-023 Exception-class event = i_exception in S_FETCH, or i_eret with i_fetch_ack and !i_stall in S_EXC.
REQ-024 PC update, single-cycle latency: next PC visible on o_pc the edge after the event.
REQ-025 i_exception in S_FETCH accepted regardless of i_stall/i_fetch_ack: EPC <= o_pc, PC <= EXC_VECTOR, state -> S_EXC.
REQ-026 i_exception in S_EXC or S_BOOT ignored (no nesting); EPC unchanged.
REQ-027 S_EXC, i_eret & i_fetch_ack & !i_stall: PC <= EPC, state -> S_FETCH; i_eret otherwise ignored, and ignored in S_FETCH.
REQ-028 Branch accepted only when i_branch_taken & i_fetch_ack & !i_stall & no exception-class event: PC <= i_branch_target.
REQ-029 Sequential advance when i_fetch_ack & !i_stall & no branch/exception-class event: PC <= PC + 4, modulo 2^PC_SIZE (wraps to 0).
REQ-030 No ack or stall (and no exception): PC holds; o_pc_select still reports 00.
REQ-031 Simultaneous branch and exception: exception wins, EPC = pre-branch o_pc, branch dropped.

Reset
REQ-032 i_rst overrides all inputs; next edge: state S_BOOT, o_pc=RESET_PC, o_epc=0, o_in_exception=0, o_misalign=0, o_fetch_req=0.
REQ-033 Reset asserted mid-exception or mid-stall discards pending state identically.

Configuration
REQ-034 Macro PC_SEQ_MISALIGN_CHECK_EN.
REQ-035 Defined: accepted branch with i_branch_target[0]=1 is instead treated as exception (EPC <= o_pc, PC <= EXC_VECTOR, S_EXC, o_pc_select=10), o_misalign pulses one cycle; in S_EXC it is ignored (PC holds, o_misalign pulses).
REQ-036 Undefined: no check, target taken as-is, o_misalign tied 0.

Verification
REQ-037 Reset release, ack held 1 -> o_pc 0, 0 (S_BOOT), 4, 8, 12; o_fetch_req low first cycle only.
REQ-038 o_pc=0x10, branch_taken, target 0x40, ack=1 -> select 01, next o_pc 0x40; repeat with ack=0 -> o_pc holds 0x10.
REQ-039 o_pc=0x20, exception and branch same cycle, stall=1 -> select 10, o_pc 0x100, o_epc 0x20, o_in_exception=1; later eret+ack -> o_pc 0x20, o_in_exception=0.
REQ-040 PC=0xFFFF_FFFC, ack -> o_pc 0x0000_0000; second exception in S_EXC -> o_epc unchanged.
REQ-041 With PC_SEQ_MISALIGN_CHECK_EN, o_pc=0x30, target 0x41 -> o_pc 0x100, o_epc 0x30, o_misalign one pulse; without macro -> o_pc 0x41.
REQ-042 i_rst asserted one cycle in S_EXC -> next edge o_pc=RESET_PC, o_epc=0, S_BOOT.
